multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32I core variant that shares one memory port and one ALU across cycles.
- Sequences fetch, decode, execute, memory and writeback, and drives all datapath enables and mux selects.
- Adds a memory ready handshake so the core tolerates multi-cycle memory.
- Sits beside the multi-cycle datapath; ALU control encoding matches the single-cycle core.

Parameters:
- RESET_PC_WRITE, 0, when 1 asserts PCWrite for one cycle after reset release so the datapath reloads its reset vector.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- op  input  7  Instr[6:0] from instruction register
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the access this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  0=PC, 1=ALUOut to memory address
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction/OldPC register enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1
- ALUSrcB  output  2  00=rs2, 01=ImmExt, 10=constant 4
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
- ALUControl  output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt
- illegal  output  1  pulses in DECODE on an unsupported opcode

Behaviour:
- State register is 4 bits, clocked on posedge clk, and cleared to FETCH by the asynchronous reset.
- While reset is high, every output is 0: all enables are gated, and selects, ImmSrc and ALUControl read 0.
- PCWrite = PCUpdate | (Branch & zero). Other outputs are a Moore function of the state. ImmSrc is combinational from op.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCUpdate are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add, computing the branch/jal target into ALUOut.
  - Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other opcode -> FETCH with no write and illegal=1 for that cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays high every cycle until mem_ready=1, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, Branch=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1, then ALUWB, which writes PC+4 to rd.
- ALU decode:
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10 -> by funct3: 000 gives add, or sub when opb5 & funct7b5 (opb5 = op[5]); 010 slt; 100 xor; 110 or; 111 and; others add.
- Instruction latency: lw 5 cycles; sw, R-type and I-type 4; beq 3; jal 4 (with mem_ready=1).
- If reset asserts mid-instruction, the state returns to FETCH immediately. No partial write may follow release.
- With RESET_PC_WRITE=1: one cycle of PCWrite=1 on the first clk edge after release, with no IRWrite, before normal FETCH operation.

Optional Feature:
- Macro MCCTRL_ILLEGAL_HALT_EN.
- Defined: an unsupported opcode in DECODE enters a HALT state instead of FETCH.
  - All enables are 0 in HALT; illegal stays high (sticky).
  - HALT is left only via reset.
- Undefined: illegal pulses for one cycle and the core continues from FETCH. The HALT state does not exist.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings (FETCH..JAL, HALT);
  - opcode constants;
  - ALUControl codes;
  - ResultSrc, ALUSrcA and ALUSrcB select codes.
- One sub-module, mc_alu_decoder: combinational ALUOp/funct3/funct7b5/opb5 -> ALUControl, instantiated once.

Test Plan:
- Reset/fetch stall: hold reset, then release with mem_ready=0 for 3 cycles -> all outputs 0 during reset; FETCH holds with IRWrite=0 and PCWrite=0; on mem_ready=1, IRWrite=1 and PCWrite=1 in the same cycle.
- R-type add x3,x1,x2 (0x002081B3) -> FETCH, DECODE, EXECUTER (ALUControl=0000, ALUSrcB=00), ALUWB (RegWrite=1); 4 cycles total.
- lw x5,8(x1) (0x0080A283) with mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles with AdrSrc=1; MEMWB has ResultSrc=01 and RegWrite=1.
- sw x5,4(x1) (0x0050A223) -> ImmSrc=01; MemWrite high every MEMWRITE cycle until mem_ready; RegWrite never asserted.
- beq x1,x2,+8 (0x00208463):
  - zero=1 -> PCWrite=1 in BEQ with ALUControl=0001.
  - zero=0 -> PCWrite=0 in BEQ.
  - Then jal x1,+16 (0x010000EF) -> ImmSrc=11; PCWrite=1 in JAL; RegWrite=1 in the following ALUWB.
- Illegal opcode 0x0000007F -> illegal=1 in DECODE, then FETCH. With MCCTRL_ILLEGAL_HALT_EN defined: HALT, enables 0, illegal stays 1 until reset.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALU control codes and datapath select codes. HALT exists only with MCCTRL_ILLEGAL_HALT_EN.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
`ifdef MCCTRL_ILLEGAL_HALT_EN
      ,
      S_HALT     = 4'd11
`endif
   } state_e;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_SW:   imm_src_of = IMM_S;
         OP_BEQ:  imm_src_of = IMM_B;
         OP_JAL:  imm_src_of = IMM_J;
         default: imm_src_of = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decode shared with the single-cycle core encoding.
module mc_alu_decoder
   import mc_ctrl_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       opb5_i,
   output logic [3:0] alu_control_o
);

   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: alu_control_o = ALU_ADD;
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // Only R-type (op[5]=1) may subtract; addi ignores immediate bit 30.
               3'b000:  alu_control_o = (opb5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b100:  alu_control_o = ALU_XOR;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM driving datapath enables and mux selects.
// Build option: MCCTRL_ILLEGAL_HALT_EN parks the FSM in HALT on an unsupported opcode.
module multicycle_controller
   import mc_ctrl_pkg::*;
#(
   parameter bit RESET_PC_WRITE = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [3:0] ALUControl,
   output logic       illegal
);

   state_e     state_q, state_d;
   logic       pcinit_q;
   logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, illegal_s;
   logic [1:0] result_src, src_a, src_b, alu_op;
   logic [3:0] alu_control;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_FETCH;
         pcinit_q <= RESET_PC_WRITE;
      end else begin
         state_q  <= state_d;
         pcinit_q <= 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      illegal_s  = 1'b0;
      result_src = RES_ALUOUT;
      src_a      = SRCA_PC;
      src_b      = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            result_src = RES_ALURESULT;
            src_b      = SRCB_FOUR;
            ir_write   = mem_ready;
            pc_update  = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            src_a = SRCA_OLDPC;
            src_b = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTER;
               OP_ITYPE:     state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  illegal_s = 1'b1;
`ifdef MCCTRL_ILLEGAL_HALT_EN
                  state_d   = S_HALT;
`else
                  state_d   = S_FETCH;
`endif
               end
            endcase
         end
         S_MEMADR: begin
            src_a   = SRCA_RS1;
            src_b   = SRCB_IMM;
            state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            src_a   = SRCA_RS1;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            src_a   = SRCA_RS1;
            src_b   = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            src_a   = SRCA_RS1;
            alu_op  = ALUOP_SUB;
            branch  = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            src_a     = SRCA_OLDPC;
            src_b     = SRCB_FOUR;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
`ifdef MCCTRL_ILLEGAL_HALT_EN
         S_HALT: begin
            illegal_s = 1'b1;
            state_d   = S_HALT;
         end
`endif
         default: state_d = S_FETCH;
      endcase
      // Reset-vector reload cycle: PC load only, FETCH is held for one more cycle.
      if (pcinit_q) begin
         state_d    = S_FETCH;
         pc_update  = 1'b1;
         branch     = 1'b0;
         ir_write   = 1'b0;
         adr_src    = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         illegal_s  = 1'b0;
         result_src = RES_ALUOUT;
         src_a      = SRCA_PC;
         src_b      = SRCB_RS2;
         alu_op     = ALUOP_ADD;
      end
   end

   mc_alu_decoder u_alu_dec (
      .alu_op_i      (alu_op),
      .funct3_i      (funct3),
      .funct7b5_i    (funct7b5),
      .opb5_i        (op[5]),
      .alu_control_o (alu_control)
   );

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = '0;
      ALUSrcA    = '0;
      ALUSrcB    = '0;
      ImmSrc     = '0;
      ALUControl = '0;
      illegal    = 1'b0;
      if (!reset) begin
         PCWrite    = pc_update | (branch & zero);
         AdrSrc     = adr_src;
         MemWrite   = mem_write;
         IRWrite    = ir_write;
         RegWrite   = reg_write;
         ResultSrc  = result_src;
         ALUSrcA    = src_a;
         ALUSrcB    = src_b;
         ImmSrc     = imm_src_of(op);
         ALUControl = alu_control;
         illegal    = illegal_s;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table, reset corner
// sequences and randomized instruction streams against a per-instruction cycle model.
module tb_multicycle_controller;

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic       rw;
      logic [1:0] rs;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] imm;
      logic [3:0] alu;
      logic       ill;
   } out_t;

   typedef struct {
      logic [31:0] instr;
      logic        rdy;
      logic        z;
      out_t        exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, zero, mem_ready, funct7b5;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [3:0] ALUControl;
   logic       pcw2, adr2, mw2, irw2, rw2, ill2;
   logic [1:0] rs2, sa2, sb2, imm2;
   logic [3:0] alu2;
   out_t       act, act2;

   int tests = 0;
   int failed = 0;
   vec_t vq[$];

   multicycle_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .illegal(illegal)
   );

   multicycle_controller #(.RESET_PC_WRITE(1'b1)) dut_pcw (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .PCWrite(pcw2), .AdrSrc(adr2),
      .MemWrite(mw2), .IRWrite(irw2), .RegWrite(rw2), .ResultSrc(rs2),
      .ALUSrcA(sa2), .ALUSrcB(sb2), .ImmSrc(imm2), .ALUControl(alu2),
      .illegal(ill2)
   );

   assign act  = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, ALUControl, illegal};
   assign act2 = {pcw2, adr2, mw2, irw2, rw2, rs2, sa2, sb2, imm2, alu2, ill2};

   always #5 clk = ~clk;

   function automatic out_t o(input logic pcw, adr, mw, irw, rw,
                              input logic [1:0] rs, sa, sb, imm,
                              input logic [3:0] alu, input logic ill);
      o = {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
   endfunction

   function automatic logic [1:0] imm_ref(input logic [6:0] opc);
      if (opc == 7'b0100011)      imm_ref = 2'b01;
      else if (opc == 7'b1100011) imm_ref = 2'b10;
      else if (opc == 7'b1101111) imm_ref = 2'b11;
      else                        imm_ref = 2'b00;
   endfunction

   // Operation an R/I-type arithmetic instruction performs.
   function automatic logic [3:0] alu_ref(input logic is_r, input logic [2:0] f3, input logic f7);
      if (f3 == 3'b000)      alu_ref = (is_r && f7) ? 4'b0001 : 4'b0000;
      else if (f3 == 3'b010) alu_ref = 4'b0101;
      else if (f3 == 3'b100) alu_ref = 4'b0100;
      else if (f3 == 3'b110) alu_ref = 4'b0011;
      else if (f3 == 3'b111) alu_ref = 4'b0010;
      else                   alu_ref = 4'b0000;
   endfunction

   task automatic chk(input string nm, input int idx, input out_t a, input out_t e);
      tests++;
      if (a !== e) begin
         failed++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, a, e);
      end
   endtask

   task automatic push(input logic [31:0] instr, input logic rdy, input logic z, input out_t e);
      vec_t v;
      v.instr = instr; v.rdy = rdy; v.z = z; v.exp = e;
      vq.push_back(v);
   endtask

   task automatic run_q(input string nm);
      int k = 0;
      while (vq.size() > 0) begin
         vec_t v;
         v = vq.pop_front();
         @(negedge clk);
         op = v.instr[6:0]; funct3 = v.instr[14:12]; funct7b5 = v.instr[30];
         mem_ready = v.rdy; zero = v.z;
         #1;
         chk(nm, k, act, v.exp);
         k++;
      end
   endtask

   // Reference cycle sequence of one instruction with given fetch/memory wait counts.
   task automatic gen_instr(input logic [31:0] instr, input int nf, input int nm);
      logic [6:0] opc;
      logic [1:0] im;
      logic       z;
      opc = instr[6:0];
      im  = imm_ref(opc);
      for (int i = 0; i < nf; i++)
         push(instr, 1'b0, 1'($urandom_range(0, 1)), o(0,0,0,0,0, 2'b10,2'b00,2'b10, im, 4'h0, 0));
      push(instr, 1'b1, 1'($urandom_range(0, 1)), o(1,0,0,1,0, 2'b10,2'b00,2'b10, im, 4'h0, 0));
      case (opc)
         7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111:
            push(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 o(0,0,0,0,0, 2'b00,2'b01,2'b01, im, 4'h0, 0));
         default:
            push(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 o(0,0,0,0,0, 2'b00,2'b01,2'b01, im, 4'h0, 1));
      endcase
      case (opc)
         7'b0110011: begin
            push(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 o(0,0,0,0,0, 2'b00,2'b10,2'b00, im, alu_ref(1'b1, instr[14:12], instr[30]), 0));
            push(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 o(0,0,0,0,1, 2'b00,2'b00,2'b00, im, 4'h0, 0));
         end
         7'b0010011: begin
            push(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 o(0,0,0,0,0, 2'b00,2'b10,2'b01, im, alu_ref(1'b0, instr[14:12], instr[30]), 0));
            push(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 o(0,0,0,0,1, 2'b00,2'b00,2'b00, im, 4'h0, 0));
         end
         7'b0000011, 7'b0100011: begin
            push(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 o(0,0,0,0,0, 2'b00,2'b10,2'b01, im, 4'h0, 0));
            for (int i = 0; i <= nm; i++) begin
               if (opc == 7'b0000011)
                  push(instr, (i == nm), 1'($urandom_range(0, 1)),
                       o(0,1,0,0,0, 2'b00,2'b00,2'b00, im, 4'h0, 0));
               else
                  push(instr, (i == nm), 1'($urandom_range(0, 1)),
                       o(0,1,1,0,0, 2'b00,2'b00,2'b00, im, 4'h0, 0));
            end
            if (opc == 7'b0000011)
               push(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    o(0,0,0,0,1, 2'b01,2'b00,2'b00, im, 4'h0, 0));
         end
         7'b1100011: begin
            z = 1'($urandom_range(0, 1));
            push(instr, 1'($urandom_range(0, 1)), z, o(z,0,0,0,0, 2'b00,2'b10,2'b00, im, 4'h1, 0));
         end
         7'b1101111: begin
            push(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 o(1,0,0,0,0, 2'b00,2'b01,2'b10, im, 4'h0, 0));
            push(instr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 o(0,0,0,0,1, 2'b00,2'b00,2'b00, im, 4'h0, 0));
         end
         default: ;
      endcase
   endtask

   localparam logic [31:0] I_ADD = 32'h002081B3;
   localparam logic [31:0] I_LW  = 32'h0080A283;
   localparam logic [31:0] I_SW  = 32'h0050A223;
   localparam logic [31:0] I_BEQ = 32'h00208463;
   localparam logic [31:0] I_JAL = 32'h010000EF;
   localparam logic [31:0] I_ILL = 32'h0000007F;

   initial begin
      out_t fs, fr, dec;
      logic [31:0] instr;
      logic [6:0]  opcs [7];
      int          ncls;
      opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1111111};

      reset = 1'b1; mem_ready = 1'b1; zero = 1'b1;
      op = I_ADD[6:0]; funct3 = 3'b000; funct7b5 = 1'b1;
      #2;
      chk("reset_out", 0, act, '0);
      chk("reset_out_pcw", 0, act2, '0);
      @(negedge clk); #1;
      chk("reset_out", 1, act, '0);

      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b0; funct7b5 = 1'b0; zero = 1'b0;
      #1;
      chk("release_fetch", 0, act, o(0,0,0,0,0, 2'b10,2'b00,2'b10, 2'b00, 4'h0, 0));

      // Directed table from the test plan.
      fs = o(0,0,0,0,0, 2'b10,2'b00,2'b10, 2'b00, 4'h0, 0);
      fr = o(1,0,0,1,0, 2'b10,2'b00,2'b10, 2'b00, 4'h0, 0);
      dec = o(0,0,0,0,0, 2'b00,2'b01,2'b01, 2'b00, 4'h0, 0);
      for (int i = 0; i < 3; i++) push(I_ADD, 0, 0, fs);
      push(I_ADD, 1, 0, fr);
      push(I_ADD, 0, 0, dec);
      push(I_ADD, 0, 0, o(0,0,0,0,0, 2'b00,2'b10,2'b00, 2'b00, 4'h0, 0));
      push(I_ADD, 0, 0, o(0,0,0,0,1, 2'b00,2'b00,2'b00, 2'b00, 4'h0, 0));
      push(I_LW, 1, 0, fr);
      push(I_LW, 1, 0, dec);
      push(I_LW, 1, 0, o(0,0,0,0,0, 2'b00,2'b10,2'b01, 2'b00, 4'h0, 0));
      push(I_LW, 0, 0, o(0,1,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 4'h0, 0));
      push(I_LW, 0, 0, o(0,1,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 4'h0, 0));
      push(I_LW, 1, 0, o(0,1,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 4'h0, 0));
      push(I_LW, 0, 0, o(0,0,0,0,1, 2'b01,2'b00,2'b00, 2'b00, 4'h0, 0));
      push(I_SW, 1, 0, o(1,0,0,1,0, 2'b10,2'b00,2'b10, 2'b01, 4'h0, 0));
      push(I_SW, 1, 0, o(0,0,0,0,0, 2'b00,2'b01,2'b01, 2'b01, 4'h0, 0));
      push(I_SW, 1, 0, o(0,0,0,0,0, 2'b00,2'b10,2'b01, 2'b01, 4'h0, 0));
      push(I_SW, 0, 0, o(0,1,1,0,0, 2'b00,2'b00,2'b00, 2'b01, 4'h0, 0));
      push(I_SW, 1, 0, o(0,1,1,0,0, 2'b00,2'b00,2'b00, 2'b01, 4'h0, 0));
      push(I_BEQ, 1, 1, o(1,0,0,1,0, 2'b10,2'b00,2'b10, 2'b10, 4'h0, 0));
      push(I_BEQ, 1, 1, o(0,0,0,0,0, 2'b00,2'b01,2'b01, 2'b10, 4'h0, 0));
      push(I_BEQ, 1, 1, o(1,0,0,0,0, 2'b00,2'b10,2'b00, 2'b10, 4'h1, 0));
      push(I_BEQ, 1, 1, o(1,0,0,1,0, 2'b10,2'b00,2'b10, 2'b10, 4'h0, 0));
      push(I_BEQ, 1, 1, o(0,0,0,0,0, 2'b00,2'b01,2'b01, 2'b10, 4'h0, 0));
      push(I_BEQ, 1, 0, o(0,0,0,0,0, 2'b00,2'b10,2'b00, 2'b10, 4'h1, 0));
      push(I_JAL, 1, 0, o(1,0,0,1,0, 2'b10,2'b00,2'b10, 2'b11, 4'h0, 0));
      push(I_JAL, 1, 0, o(0,0,0,0,0, 2'b00,2'b01,2'b01, 2'b11, 4'h0, 0));
      push(I_JAL, 1, 0, o(1,0,0,0,0, 2'b00,2'b01,2'b10, 2'b11, 4'h0, 0));
      push(I_JAL, 1, 0, o(0,0,0,0,1, 2'b00,2'b00,2'b00, 2'b11, 4'h0, 0));
      run_q("table");

      // Unsupported opcode.
      push(I_ILL, 1, 0, fr);
      push(I_ILL, 1, 0, o(0,0,0,0,0, 2'b00,2'b01,2'b01, 2'b00, 4'h0, 1));
`ifdef MCCTRL_ILLEGAL_HALT_EN
      for (int i = 0; i < 3; i++)
         push(I_ILL, 1, 1, o(0,0,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 4'h0, 1));
      run_q("halt");
      @(negedge clk); reset = 1'b1; #1;
      chk("halt_reset", 0, act, '0);
      @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
      chk("halt_release", 0, act, fs);
`else
      push(I_ILL, 0, 0, fs);
      run_q("illegal");
`endif

      // Reset mid-lw, then release with memory ready.
      push(I_LW, 1, 0, fr);
      push(I_LW, 1, 0, dec);
      push(I_LW, 1, 0, o(0,0,0,0,0, 2'b00,2'b10,2'b01, 2'b00, 4'h0, 0));
      push(I_LW, 0, 0, o(0,1,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 4'h0, 0));
      run_q("midreset_pre");
      @(negedge clk); reset = 1'b1; mem_ready = 1'b1; #1;
      chk("midreset_out", 0, act, '0);
      chk("midreset_out_pcw", 0, act2, '0);
      @(negedge clk); #1;
      chk("midreset_out", 1, act, '0);
      @(negedge clk); reset = 1'b0; #1;
      chk("midreset_release", 0, act, fr);
      chk("pcw_reload", 0, act2, o(1,0,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 4'h0, 0));
      @(negedge clk); #1;
      chk("midreset_decode", 0, act, dec);
      chk("pcw_fetch", 0, act2, fr);
      push(I_LW, 1, 0, o(0,0,0,0,0, 2'b00,2'b10,2'b01, 2'b00, 4'h0, 0));
      push(I_LW, 1, 0, o(0,1,0,0,0, 2'b00,2'b00,2'b00, 2'b00, 4'h0, 0));
      push(I_LW, 1, 0, o(0,0,0,0,1, 2'b01,2'b00,2'b00, 2'b00, 4'h0, 0));
      run_q("midreset_post");

      // Randomized instruction stream.
`ifdef MCCTRL_ILLEGAL_HALT_EN
      ncls = 6;
`else
      ncls = 7;
`endif
      for (int n = 0; n < 150; n++) begin
         instr = $urandom;
         instr[6:0] = opcs[$urandom_range(0, ncls - 1)];
         if (instr[6:0] == 7'b0000011 || instr[6:0] == 7'b0100011) instr[14:12] = 3'b010;
         if (instr[6:0] == 7'b1100011) instr[14:12] = 3'b000;
         gen_instr(instr, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
      run_q("random");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
